// File: rtl/display_pkg.sv
// ============================================================================
// Module      : display_pkg
// Description : Shared seven-segment display types, glyph constants and the
//               nibble-to-segment decode function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    // Widest display the scanner supports; the anode bus is sized for this.
    localparam int MAX_DIGITS = 8;

    // Segment vector ordered {g,f,e,d,c,b,a}, active-low (0 = segment lit).
    typedef logic [6:0] seg_t;

    // One BCD digit as delivered by the upstream BCD peripheral.
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_0    = 7'b1000000;
    localparam seg_t SEG_1    = 7'b1111001;
    localparam seg_t SEG_2    = 7'b0100100;
    localparam seg_t SEG_3    = 7'b0110000;
    localparam seg_t SEG_4    = 7'b0011001;
    localparam seg_t SEG_5    = 7'b0010010;
    localparam seg_t SEG_6    = 7'b0000010;
    localparam seg_t SEG_7    = 7'b1111000;
    localparam seg_t SEG_8    = 7'b0000000;
    localparam seg_t SEG_9    = 7'b0010000;
    localparam seg_t SEG_DASH = 7'b0111111;
    localparam seg_t SEG_OFF  = 7'b1111111;

    // Nibble-to-segment mapping: nibble_t -> seg_t. Non-BCD codes show a dash
    // so a corrupted upstream value is visible rather than silently wrong.
    function automatic seg_t nibble_to_seg(input nibble_t nib);
        seg_t seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module      : seg7_decode
// Description : Combinational BCD nibble to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    // Pure lookup; the caller registers the result.
    assign o_seg = nibble_to_seg(i_nib);

endmodule

`default_nettype wire

// File: rtl/peri_7seg_scan.sv
// ============================================================================
// Module      : peri_7seg_scan
// Description : Time-multiplexed seven-segment scanner. Snapshots the packed
//               BCD word once per frame and lights one digit per slot, with
//               a blanking gap at the start of every slot against ghosting.
//               Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peri_7seg_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS    = 6,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 4
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] bcd_i,
    input  logic [7:0]  dp_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam int              PW          = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]   C_PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW:0]     C_BLANK     = (PW + 1)'(BLANK_CYC);
    localparam logic [2:0]      C_IDX_LAST  = 3'(N_DIGITS - 1);

    logic [PW-1:0] r_pcnt;
    logic [2:0]    r_idx;
    logic [31:0]   r_bcd;
    logic [7:0]    r_dpq;
    logic          r_first;
    logic          r_frame;
    logic [7:0]    r_an;
    seg_t          r_seg;
    logic          r_dp;

    logic          w_tc;
    logic          w_wrap;
    logic          w_snap;
    logic [3:0]    w_nib;
    seg_t          w_seg_dec;
    logic          w_show;
    logic          w_lit;

    assign w_tc   = (r_pcnt == C_PCNT_LAST);
    assign w_wrap = w_tc && (r_idx == C_IDX_LAST);
    // The first cycle after reset behaves like a frame wrap so the display
    // does not sit on the all-zero reset snapshot for a whole frame.
    assign w_snap = w_wrap || r_first;

    // Prescaler and digit index; held on the post-reset snapshot cycle so the
    // first slot is full length and aligned with the frame pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pcnt <= '0;
            r_idx  <= 3'd0;
        end else if (r_first) begin
            r_pcnt <= '0;
            r_idx  <= 3'd0;
        end else if (w_tc) begin
            r_pcnt <= '0;
            r_idx  <= w_wrap ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    // Frame snapshot of BCD word and decimal points; no tearing mid-frame.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bcd   <= 32'd0;
            r_dpq   <= 8'd0;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (w_snap) begin
                r_bcd <= bcd_i;
                r_dpq <= dp_i;
            end
        end
    end

    assign w_nib = r_bcd[{r_idx, 2'b00} +: 4];

    seg7_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] w_msd;

    // Highest digit holding a non-zero nibble or a lit decimal point.
    always_comb begin
        w_msd = 3'd0;
        for (int k = 1; k < N_DIGITS; k++) begin
            if ((r_bcd[4*k +: 4] != 4'd0) || r_dpq[k]) begin
                w_msd = 3'(k);
            end
        end
    end

    assign w_show = (r_idx <= w_msd);
`else
    assign w_show = 1'b1;
`endif

    assign w_lit = en_i && w_show && ({1'b0, r_pcnt} >= C_BLANK);

    // Registered pin drivers: one cycle behind the scan state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_an    <= 8'hFF;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_snap;
            if (w_lit) begin
                r_an  <= ~(8'd1 << r_idx);
                r_seg <= w_seg_dec;
                r_dp  <= ~r_dpq[r_idx];
            end else begin
                r_an  <= 8'hFF;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end
        end
    end

    assign an_o    = r_an;
    assign seg_o   = r_seg;
    assign dp_o    = r_dp;
    assign frame_o = r_frame;

endmodule

`default_nettype wire
